wallace_mul_pipe: RTL
=====================

Name: wallace_mul_pipe

Overview:
- Parametrised, pipelined Wallace-tree multiplier; successor to the 4x4 combinational Wallace multiplier.
- Generalised operand width, configurable pipeline depth, runtime signed/unsigned mode, valid/ready handshake on both sides.
- Sits between an operand producer (register file / DSP datapath) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..32).
- PIPE_STAGES, 2, register stages inside the partial-product reduction tree (legal 0..4).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat this cycle.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- signed_mode  input  1  1: A, B, Result are two's complement; 0: unsigned. Sampled with the beat.
- out_valid  output  1  Result holds a valid product.
- out_ready  input  1  consumer accepts Result this cycle.
- Result  output  2*WIDTH  product.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). On rst=1 at a rising edge, every valid bit in the pipe clears. out_valid=0, Result=0, in_ready=1 in the cycle after reset. Operand/data registers may stay unreset, except Result, which is forced to 0.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stall rule: global stall = out_valid && !out_ready. in_ready = !stall, which is combinational from out_valid/out_ready.
  - While stalled, every pipe register holds. Result and out_valid stay stable until accepted.
- Latency L = PIPE_STAGES + 2 cycles from the input transfer edge to out_valid high, with no stall:
  - 1 input capture register;
  - PIPE_STAGES reduction registers;
  - 1 output register after the final carry-propagate adder.
  - Throughput is 1 product per cycle.
- Bubbles are not collapsed. An empty slot advances when not stalled.
- Arithmetic:
  - Partial products are generated as an AND array.
  - Signed mode uses Baugh-Wooley: MSB-row/column products are inverted, and constants are added at columns WIDTH and 2*WIDTH-1.
  - Reduction uses 3:2 full adders and 2:2 half adders in Wallace grouping until two rows remain, then a ripple or prefix adder.
  - Result is the exact 2*WIDTH-bit product with no truncation. The signed_mode bit travels down the pipe with its operands.
- Boundaries:
  - Unsigned max*max gives (2^WIDTH-1)^2.
  - Signed min*min gives +2^(2*WIDTH-2), which is representable.
  - Operand 0 gives Result 0.
- Simultaneous events:
  - Input and output transfers may occur in the same cycle.
  - An input transfer is legal whenever out_ready=1, even if out_valid=1.
- rst asserted mid-operation flushes all in-flight beats. No output transfer occurs for them.

Optional Feature:
- Macro: WALLACE_MUL_OPCNT_EN.
- Defined: adds output op_count [15:0], the number of completed output transfers. It is reset to 0 by rst and wraps 0xFFFF->0x0000. It increments in the cycle after each out_valid && out_ready.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, Result=0, in_ready=1 after release; no spurious output.
- Unsigned sweep, WIDTH=4, PIPE_STAGES=0: all 256 A/B pairs, out_ready=1 -> each Result equals A*B exactly 2 cycles later (e.g. 15*15=225, 9*7=63).
- Signed, WIDTH=8, PIPE_STAGES=2: -128*-128 -> 0x4000; -1*127 -> 0xFF81; -128*127 -> 0xC080; latency 4 cycles.
- Backpressure: stream 10 random beats, toggle out_ready randomly -> in_ready=0 exactly when out_valid && !out_ready; Result stable while stalled; results in order, none lost or duplicated.
- Mid-operation reset: 3 beats in flight, assert rst one cycle -> zero outputs emitted; the next beat 5*6 unsigned yields 30 after L cycles.
- WALLACE_MUL_OPCNT_EN: 65537 accepted products -> op_count=1 (wrap); stalled cycles do not increment.

Source files
------------

// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined Wallace-tree multiplier with valid/ready on both sides.
// Signed mode uses Baugh-Wooley partial products. Pipe registers: input capture,
// PIPE_STAGES registers spread over the reduction levels, and an output register
// after the final carry-propagate adder.
// Optional macro WALLACE_MUL_OPCNT_EN adds op_count, a wrapping count of output transfers.
module wallace_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Result
`ifdef WALLACE_MUL_OPCNT_EN
  ,
  output logic [15:0]          op_count
`endif
);

  localparam int PW     = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the Baugh-Wooley constants.
  localparam int NR     = WIDTH + 1;
  localparam int MAXLEV = 16;

  typedef logic [NR-1:0][PW-1:0] rows_t;

  function automatic int next_rows(input int n);
    return (n > 2) ? (2 * (n / 3) + (n % 3)) : n;
  endfunction

  function automatic int num_levels(input int n);
    int l;
    int m;
    l = 0;
    m = n;
    for (int i = 0; i < MAXLEV; i++) begin
      if (m > 2) begin
        m = next_rows(m);
        l++;
      end
    end
    return l;
  endfunction

  localparam int NLEV = num_levels(NR);

  // One Wallace level: every full group of three rows becomes a sum row and a
  // shifted carry row; the leftover one or two rows pass straight through.
  function automatic rows_t csa_level(input rows_t r, input int n);
    rows_t o;
    int    g3;
    o  = '0;
    g3 = n / 3;
    for (int g = 0; g < NR / 3; g++) begin
      if (g < g3) begin
        o[2*g]   = r[3*g] ^ r[3*g+1] ^ r[3*g+2];
        o[2*g+1] = ((r[3*g] & r[3*g+1]) | (r[3*g] & r[3*g+2]) | (r[3*g+1] & r[3*g+2])) << 1;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if ((i >= 3 * g3) && (i < n)) o[i-g3] = r[i];
    end
    return o;
  endfunction

  // Applies levels [lo, hi) of the tree; row count is tracked from the full tree.
  function automatic rows_t reduce_span(input rows_t r, input int lo, input int hi);
    rows_t t;
    int    n;
    t = r;
    n = NR;
    for (int l = 0; l < MAXLEV; l++) begin
      if ((l >= lo) && (l < hi)) t = csa_level(t, n);
      n = next_rows(n);
    end
    return t;
  endfunction

  logic             stall;
  logic             in_vld_q, in_vld_d;
  logic [WIDTH-1:0] in_a_q, in_a_d;
  logic [WIDTH-1:0] in_b_q, in_b_d;
  logic             in_sgn_q, in_sgn_d;
  logic             out_vld_q, out_vld_d;
  logic [PW-1:0]    result_q, result_d;
  logic [PW-1:0]    final_sum;
  rows_t            pp_rows;
  rows_t            seg_in  [PIPE_STAGES+1];
  rows_t            seg_out [PIPE_STAGES+1];
  logic             vld_in  [PIPE_STAGES+1];
  logic             leftover_unused;

  assign stall     = out_vld_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = out_vld_q;
  assign Result    = result_q;

  // Input capture: load operands on an accepted beat, bubble otherwise, hold on stall.
  always_comb begin
    in_vld_d = in_vld_q;
    in_a_d   = in_a_q;
    in_b_d   = in_b_q;
    in_sgn_d = in_sgn_q;
    if (!stall) begin
      in_vld_d = in_valid;
      if (in_valid) begin
        in_a_d   = A;
        in_b_d   = B;
        in_sgn_d = signed_mode;
      end
    end
  end

  // Partial-product AND array; signed mode inverts the MSB cross terms and adds
  // the constants at columns WIDTH and 2*WIDTH-1.
  always_comb begin
    pp_rows = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        pp_rows[j][i+j] = (in_a_q[i] & in_b_q[j]) ^
                          (in_sgn_q & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    pp_rows[WIDTH][WIDTH]  = in_sgn_q;
    pp_rows[WIDTH][PW-1]   = in_sgn_q;
  end

  assign seg_in[0] = pp_rows;
  assign vld_in[0] = in_vld_q;

  // Reduction levels are split as evenly as possible between the register stages.
  for (genvar s = 0; s <= PIPE_STAGES; s++) begin : g_seg
    localparam int LO = (s * NLEV) / (PIPE_STAGES + 1);
    localparam int HI = ((s + 1) * NLEV) / (PIPE_STAGES + 1);
    assign seg_out[s] = reduce_span(seg_in[s], LO, HI);
  end

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_red
    rows_t rows_q, rows_d;
    logic  vld_q, vld_d;

    // Advance one reduction slot unless the pipe is stalled; bubbles advance too.
    always_comb begin
      rows_d = rows_q;
      vld_d  = vld_q;
      if (!stall) begin
        vld_d = vld_in[s];
        if (vld_in[s]) rows_d = seg_out[s];
      end
    end

    // Slot valid flag, cleared by reset.
    always_ff @(posedge clk) begin
      if (rst) vld_q <= 1'b0;
      else     vld_q <= vld_d;
    end

    // Slot data, no reset needed.
    always_ff @(posedge clk) begin
      rows_q <= rows_d;
    end

    assign seg_in[s+1] = rows_q;
    assign vld_in[s+1] = vld_q;
  end

  // After the last level only rows 0 and 1 can be non-zero.
  assign final_sum       = seg_out[PIPE_STAGES][0] + seg_out[PIPE_STAGES][1];
  assign leftover_unused = |seg_out[PIPE_STAGES][NR-1:2];

  // Output register: load the product when a valid beat arrives, hold on stall.
  always_comb begin
    out_vld_d = out_vld_q;
    result_d  = result_q;
    if (!stall) begin
      out_vld_d = vld_in[PIPE_STAGES];
      if (vld_in[PIPE_STAGES]) result_d = final_sum;
    end
  end

  // Valid flags and Result are reset; Result reads 0 right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      result_q  <= '0;
    end else begin
      in_vld_q  <= in_vld_d;
      out_vld_q <= out_vld_d;
      result_q  <= result_d;
    end
  end

  // Operand capture registers, no reset needed.
  always_ff @(posedge clk) begin
    in_a_q   <= in_a_d;
    in_b_q   <= in_b_d;
    in_sgn_q <= in_sgn_d;
  end

`ifdef WALLACE_MUL_OPCNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  // Count completed output transfers, wrapping at 16 bits.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (out_vld_q && out_ready) op_cnt_d = op_cnt_q + 16'd1;
  end

  // Transfer counter register.
  always_ff @(posedge clk) begin
    if (rst) op_cnt_q <= '0;
    else     op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`endif

endmodule
